tick_scheduler: RTL and testbench
=================================

# tick_scheduler

Programmable clock-enable scheduler for the 100 MHz `clk` domain. It generates phase-aligned single-cycle tick pulses and 50% square waves on four channels. Each channel's period is reprogrammed at runtime through a valid/ready config port, and updates take effect only at that channel's period boundary so no consumer ever sees a short or long period. Downstream display, debounce, buzzer and game-timer logic uses `tick[i]` as a clock enable instead of a derived clock.

## Interface
- `CW`, 27: period/counter width in bits.
- `P0`, 10000000: channel 0 reset period in `clk` cycles (10 Hz).
- `P1`, 100000000: channel 1 reset period (1 Hz).
- `P2`, 50000: channel 2 reset period (2 kHz).
- `P3`, 1000000: channel 3 reset period (100 Hz).

- `clk`  in  1  system clock, 100 MHz.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  level; sampled each edge; IDLE→RUN.
- `stop`  in  1  level; sampled each edge; RUN→IDLE.
- `cfg_valid`  in  1  config request.
- `cfg_ready`  out  1  config slot free.
- `cfg_chan`  in  2  target channel.
- `cfg_period`  in  CW  new period in cycles.
- `cfg_err`  out  1  one-cycle pulse: accepted request had period 0.
- `tick`  out  4  one-cycle enable pulse per channel.
- `sq`  out  4  square wave per channel; toggles on each tick.
- `running`  out  1  high in RUN.

## Operation
- FSM states are IDLE and RUN; reset enters IDLE.
  - IDLE→RUN when `start`=1.
  - RUN→IDLE when `stop`=1.
  - `stop` wins if both inputs are high.
  - `start` in RUN and `stop` in IDLE are ignored.
- Per-channel state: `period[i]` (CW bits) and counter `cnt[i]` (CW bits).
- In IDLE:
  - all `cnt` are held at 0.
  - `tick`=0.
  - `sq` holds its last value.
- On the IDLE→RUN edge, all `cnt` are cleared to 0, so all channels start phase-aligned.
- In RUN, each edge: if `cnt[i]==period[i]-1`, then `cnt[i]`←0, `tick[i]`←1 and `sq[i]`←~`sq[i]` (this is a "wrap"). Otherwise `cnt[i]`+1 and `tick[i]`←0.
- Period 1 gives `tick` high every cycle and `sq` at clk/2.
- Config handshake:
  - A request is accepted on an edge with `cfg_valid`&&`cfg_ready`.
  - `cfg_period`=0: nothing is stored, `cfg_err`=1 for the next cycle, and `cfg_ready` stays 1.
  - Otherwise the request loads a single pending slot (chan, period) and `cfg_ready` drops to 0 the cycle after acceptance.
- Applying a pending update:
  - In RUN, the update applies on the first edge at which the target channel wraps and the slot was already valid before that edge. An accept coinciding with a wrap edge applies at the next wrap.
  - The wrap that applies it uses the old period for its compare; `cnt`←0 and the new period governs from then on.
  - In IDLE, the pending update applies on the next edge.
  - `cfg_ready` returns to 1 the cycle after the apply edge.
- `stop` while an update is pending: the update applies on the first IDLE edge.
- Reset mid-operation: everything returns to the reset values below and any pending update is discarded.

## Timing
- Reset values:
  - `tick`=0, `sq`=0, `running`=0, `cfg_ready`=1, `cfg_err`=0.
  - `period[i]`=P_i, `cnt[i]`=0, FSM=IDLE, pending slot empty.
- All outputs are registered, with no combinational input→output paths.
- `running` rises the cycle after the `start` sampling edge and falls the cycle after the `stop` sampling edge.
- Channel i ticks:
  - With `start` sampled at edge E0, the first `tick[i]` is high after edge E0+P_i for one cycle.
  - Later ticks come every P_i cycles.
- Stop takes effect on the sampling edge: no tick is asserted after it, even if a wrap was due that edge.
- Maximum config throughput is one update per target-channel period.

## Test plan
- Params P0=4, P1=5, P2=7, P3=10. Reset, assert `start` 1 cycle → `tick[0]` high at cycles 4, 8, 12; `tick[3]` at 10, 20; `sq[0]` toggles at each tick; `running` high from cycle 1.
- In RUN, write chan 1, period 3 mid-period → `cfg_ready` low until the next `tick[1]`. Ticks continue at spacing 5 up to and including that wrap, then spacing 3. `cfg_ready` is high 1 cycle after the apply edge.
- Write accepted on the same edge as a `tick[2]` wrap → old period 7 is kept for one more full period, then the new period applies.
- `cfg_period`=0 → `cfg_err` is a 1-cycle pulse, the period is unchanged, and `cfg_ready` never drops.
- `start` and `stop` both high in RUN → IDLE with `tick`=0. Pending update during `stop` → applied on the next edge. Restart → all channels re-aligned: first `tick[i]` at P_i.
- Drop `rst_n` asynchronously mid-period with a pending update → outputs clear immediately, periods revert to P_i, `cfg_ready`=1, and there are no ticks until `start`.

Source files
------------

// File: rtl/tick_scheduler.sv
// rtl/tick_scheduler.sv - four-channel phase-aligned tick / square-wave scheduler with boundary-safe reprogramming
module tick_scheduler #(
    parameter int CW = 27,
    parameter int P0 = 10000000,
    parameter int P1 = 100000000,
    parameter int P2 = 50000,
    parameter int P3 = 1000000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          stop,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [1:0]    cfg_chan,
    input  logic [CW-1:0] cfg_period,
    output logic          cfg_err,
    output logic [3:0]    tick,
    output logic [3:0]    sq,
    output logic          running
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [CW-1:0] ONE = CW'(1);
    localparam logic [CW-1:0] RST_P [4] = '{CW'(P0), CW'(P1), CW'(P2), CW'(P3)};

    state_t        state;
    logic [CW-1:0] period [4];
    logic [CW-1:0] cnt    [4];
    logic [1:0]    pend_chan;
    logic [CW-1:0] pend_period;
    logic [3:0]    wrap;

    always_comb begin
        wrap = '0;
        for (int i = 0; i < 4; i++) begin
            wrap[i] = (cnt[i] == period[i] - ONE);
        end
    end

    // The pending slot is occupied exactly when cfg_ready is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            running     <= 1'b0;
            tick        <= '0;
            sq          <= '0;
            cfg_ready   <= 1'b1;
            cfg_err     <= 1'b0;
            pend_chan   <= '0;
            pend_period <= '0;
            for (int i = 0; i < 4; i++) begin
                period[i] <= RST_P[i];
                cnt[i]    <= '0;
            end
        end else begin
            cfg_err <= 1'b0;
            if (cfg_valid && cfg_ready) begin
                if (cfg_period == '0) begin
                    cfg_err <= 1'b1;
                end else begin
                    cfg_ready   <= 1'b0;
                    pend_chan   <= cfg_chan;
                    pend_period <= cfg_period;
                end
            end

            case (state)
                IDLE: begin
                    tick <= '0;
                    for (int i = 0; i < 4; i++) begin
                        cnt[i] <= '0;
                    end
                    if (!cfg_ready) begin
                        period[pend_chan] <= pend_period;
                        cfg_ready         <= 1'b1;
                    end
                    if (start && !stop) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                RUN: begin
                    if (stop) begin
                        // A wrap due on this edge is suppressed; the pending slot waits for IDLE.
                        state   <= IDLE;
                        running <= 1'b0;
                        tick    <= '0;
                        for (int i = 0; i < 4; i++) begin
                            cnt[i] <= '0;
                        end
                    end else begin
                        for (int i = 0; i < 4; i++) begin
                            if (wrap[i]) begin
                                cnt[i]  <= '0;
                                tick[i] <= 1'b1;
                                sq[i]   <= ~sq[i];
                            end else begin
                                cnt[i]  <= cnt[i] + ONE;
                                tick[i] <= 1'b0;
                            end
                        end
                        if (!cfg_ready && wrap[pend_chan]) begin
                            period[pend_chan] <= pend_period;
                            cfg_ready         <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tick_scheduler.sv
// tb/tb_tick_scheduler.sv - directed self-checking bench for tick_scheduler
module tb_tick_scheduler;

    localparam int CW = 27;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          stop;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [1:0]    cfg_chan;
    logic [CW-1:0] cfg_period;
    logic          cfg_err;
    logic [3:0]    tick;
    logic [3:0]    sq;
    logic          running;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int p [4]  = '{4, 5, 7, 10};
    logic [3:0] e_t;
    logic [3:0] e_s;

    tick_scheduler #(.CW(CW), .P0(4), .P1(5), .P2(7), .P3(10)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_chan   (cfg_chan),
        .cfg_period (cfg_period),
        .cfg_err    (cfg_err),
        .tick       (tick),
        .sq         (sq),
        .running    (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic adv();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0;
        cfg_valid = 1'b0; cfg_chan = 2'd0; cfg_period = '0;
        repeat (2) adv();
        chk("rst_tick", 32'(tick), 32'h0);
        chk("rst_sq", 32'(sq), 32'h0);
        chk("rst_running", 32'(running), 32'h0);
        chk("rst_cfg_ready", 32'(cfg_ready), 32'h1);
        chk("rst_cfg_err", 32'(cfg_err), 32'h0);
        rst_n = 1'b1;
        adv();
        chk("idle_tick", 32'(tick), 32'h0);

        // Start sampled at E0; channel i ticks after E0 + k*P_i
        start = 1'b1;
        adv();
        start = 1'b0;
        cyc = 0;
        chk("running_rise", 32'(running), 32'h1);
        while (cyc < 20) begin
            adv();
            for (int i = 0; i < 4; i++) begin
                e_t[i] = (cyc % p[i]) == 0;
                e_s[i] = ((cyc / p[i]) % 2) == 1;
            end
            chk("run_tick", 32'(tick), 32'(e_t));
            chk("run_sq", 32'(sq), 32'(e_s));
        end

        // Mid-period write: chan 1 -> 3, applied at wrap 25
        adv(); adv();
        cfg_valid = 1'b1; cfg_chan = 2'd1; cfg_period = CW'(3);
        adv();
        cfg_valid = 1'b0;
        chk("ch1_ready_low", 32'(cfg_ready), 32'h0);
        while (cyc < 35) begin
            adv();
            chk("ch1_tick", 32'(tick[1]),
                (cyc <= 25) ? 32'((cyc % 5) == 0) : 32'(((cyc - 25) % 3) == 0));
            chk("ch1_ready", 32'(cfg_ready), 32'(cyc >= 25));
        end

        // Accept coincides with chan 2 wrap at 42: old period survives to 49
        while (cyc < 41) adv();
        cfg_valid = 1'b1; cfg_chan = 2'd2; cfg_period = CW'(2);
        adv();
        cfg_valid = 1'b0;
        chk("ch2_wrap_at_accept", 32'(tick[2]), 32'h1);
        chk("ch2_ready_low", 32'(cfg_ready), 32'h0);
        while (cyc < 54) begin
            adv();
            chk("ch2_tick", 32'(tick[2]),
                32'(cyc == 49 || (cyc > 49 && ((cyc - 49) % 2) == 0)));
            chk("ch2_ready", 32'(cfg_ready), 32'(cyc >= 49));
        end

        // Zero period: error pulse, no slot use
        adv();
        cfg_valid = 1'b1; cfg_chan = 2'd0; cfg_period = '0;
        adv();
        cfg_valid = 1'b0;
        chk("zero_err_pulse", 32'(cfg_err), 32'h1);
        chk("zero_ready_high", 32'(cfg_ready), 32'h1);
        chk("zero_ch0_tick56", 32'(tick[0]), 32'h1);
        adv();
        chk("zero_err_clear", 32'(cfg_err), 32'h0);
        chk("zero_ready_still", 32'(cfg_ready), 32'h1);
        while (cyc < 60) begin
            adv();
            chk("zero_ch0_period", 32'(tick[0]), 32'(cyc == 60));
        end

        // Pending chan 3 update, then start+stop together while chan 2 wrap is due
        cfg_valid = 1'b1; cfg_chan = 2'd3; cfg_period = CW'(2);
        adv();
        cfg_valid = 1'b0;
        chk("ch3_ready_low", 32'(cfg_ready), 32'h0);
        adv();
        start = 1'b1; stop = 1'b1;
        adv();
        start = 1'b0; stop = 1'b0;
        chk("stop_running", 32'(running), 32'h0);
        chk("stop_tick", 32'(tick), 32'h0);
        chk("stop_sq", 32'(sq), 32'h7);
        chk("stop_ready_pending", 32'(cfg_ready), 32'h0);
        adv();
        chk("idle_apply_ready", 32'(cfg_ready), 32'h1);
        chk("idle_tick0", 32'(tick), 32'h0);
        chk("idle_running", 32'(running), 32'h0);
        adv();
        chk("idle_sq_hold", 32'(sq), 32'h7);

        // Restart with periods 4,3,2,2: all channels re-aligned
        start = 1'b1;
        adv();
        start = 1'b0;
        cyc = 0;
        chk("restart_running", 32'(running), 32'h1);
        while (cyc < 6) begin
            adv();
            e_t = {(cyc % 2) == 0, (cyc % 2) == 0, (cyc % 3) == 0, (cyc % 4) == 0};
            chk("restart_tick", 32'(tick), 32'(e_t));
        end

        // Async reset with a pending update
        cfg_valid = 1'b1; cfg_chan = 2'd0; cfg_period = CW'(9);
        adv();
        cfg_valid = 1'b0;
        chk("pre_rst_ready", 32'(cfg_ready), 32'h0);
        chk("pre_rst_running", 32'(running), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_tick", 32'(tick), 32'h0);
        chk("async_sq", 32'(sq), 32'h0);
        chk("async_running", 32'(running), 32'h0);
        chk("async_ready", 32'(cfg_ready), 32'h1);
        chk("async_err", 32'(cfg_err), 32'h0);
        adv(); adv();
        rst_n = 1'b1;
        repeat (12) begin
            adv();
            chk("post_rst_no_tick", 32'(tick), 32'h0);
        end
        start = 1'b1;
        adv();
        start = 1'b0;
        cyc = 0;
        while (cyc < 10) begin
            adv();
            for (int i = 0; i < 4; i++) begin
                e_t[i] = (cyc % p[i]) == 0;
                e_s[i] = ((cyc / p[i]) % 2) == 1;
            end
            chk("revert_tick", 32'(tick), 32'(e_t));
            chk("revert_sq", 32'(sq), 32'(e_s));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
